modn_cascade: RTL and testbench
===============================

# modn_cascade

Parametrised cascadable modulo-N up/down counter: DIGITS digits, each counting modulo MODULUS, chained so each digit ripples into the next. It adds parallel load, an optional saturating mode, and a registered wrap pulse. Generalises the single-digit mod-7 tick counter, which is the MODULUS=7, DIGITS=1, sat=0, load=0 case. Sits in the timer/display path wherever a multi-digit non-binary count is needed (for example weeks/days or base-N displays).

## Interface
- MODULUS, 7, per-digit modulus, ≥2
- DIGITS, 2, number of chained digits, ≥1
- W (localparam), $clog2(MODULUS), bits per digit
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- dir  in  1  1=count up, 0=count down
- now  in  1  tick enable, one count step per cycle when high
- sat  in  1  1=saturate at ends, 0=wrap around
- load  in  1  parallel load request
- load_value  in  DIGITS*W  load data, digit i at bits [i*W +: W], digit 0 least significant
- value  out  DIGITS*W  current count, same packing as load_value
- wrap  out  1  registered pulse, high for the cycle in which value shows a just-wrapped count
- at_max  out  1  combinational, all digits == MODULUS-1
- at_zero  out  1  combinational, all digits == 0

## Operation
- Priority each cycle: rst, then load, then now, then hold.
- rst: all digits set to 0; wrap set to 0.
- load: digit i takes load_value digit i if it is < MODULUS, else MODULUS-1 (clamp). wrap set to 0. now is ignored that cycle.
- now=1, dir=1: digit 0 increments. Digit i>0 increments only when all lower digits == MODULUS-1. An incrementing digit at MODULUS-1 goes to 0.
- now=1, dir=0: digit 0 decrements. Digit i>0 decrements only when all lower digits == 0. A decrementing digit at 0 goes to MODULUS-1.
- Full-chain wrap:
  - up at at_max gives all digits 0.
  - down at at_zero gives all digits MODULUS-1.
  - Either case sets wrap=1 on that edge.
- sat=1 changes only the full-chain wrap case. Up at at_max and down at at_zero hold value and set wrap=0. Intra-chain digit rollover still occurs (for example {0,6} up gives {1,0}).
- now=0 with no load: value held, wrap=0.
- dir and sat are sampled only in cycles where now=1 and load=0. Changing them at any time is legal.
- Digit values never leave 0..MODULUS-1, including when MODULUS is not a power of two.

## Timing
- Latency is one cycle: inputs sampled at edge k are reflected in value and wrap after edge k.
- wrap is registered, never combinational from inputs, and high for exactly one cycle per wrap event.
- Back-to-back wraps are allowed; for example DIGITS=1, MODULUS=2, sat=0 gives wrap high on consecutive cycles.
- at_max and at_zero are combinational from the value register only. They are glitch-free relative to the clock and carry no extra latency.
- Reset mid-count: value=0 and wrap=0 after the edge where rst=1, regardless of now or load.
- Reset values: value=0, wrap=0, at_zero=1, at_max=0.

## Structure
- Package modn_pkg holds:
  - direction constants DIR_UP=1'b1, DIR_DOWN=1'b0
  - a function digit_clamp(v, MODULUS) used for load clamping
- Sub-module modn_digit holds one digit register. Its ports are clk, rst, en, dir, load, ld_val, value, at_top, at_bot.
- modn_cascade does the following:
  - generates DIGITS instances of modn_digit
  - builds the ripple enable chain from the lower digits' at_top/at_bot
  - applies the sat gating
  - owns the wrap register

## Test plan
All scenarios use MODULUS=7, DIGITS=2. Values are written as {d1,d0}.
- Reset: rst=1 with now=1 and load=1 → value={0,0}, wrap=0, at_zero=1. Repeat mid-count at {4,2} → {0,0} next cycle.
- Up sweep: sat=0, dir=1, now=1 for 48 cycles from {0,0} → {6,6}, at_max=1, wrap never high. 49th tick → {0,0} and wrap=1 for exactly one cycle. Also check {0,6}→{1,0} with wrap=0.
- Down wrap: from {0,0}, dir=0, one tick → {6,6} with wrap=1. Next tick → {6,5} with wrap=0.
- Saturation: sat=1 at {6,6}, dir=1, 3 ticks → value stays {6,6}, wrap=0. At {0,0}, dir=0 → stays {0,0}.
- Load: load_value={3,1} → {3,1}. load_value with digit 0 = 7 → digit 0 clamps to 6. load=1 and now=1 in the same cycle → loaded value, no increment.
- Hold: now=0 for 10 cycles while toggling dir and sat → value unchanged, wrap=0.

Source files
------------

// File: rtl/modn_pkg.sv
// Shared constants and helpers for the cascadable modulo-N counter.
package modn_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Out-of-range load data saturates to the top digit value.
    function automatic int unsigned digit_clamp(input int unsigned v, input int unsigned modulus);
        return (v < modulus) ? v : modulus - 1;
    endfunction

endpackage

// File: rtl/modn_cascade_if.sv
// Control/data bundle for modn_cascade; master drives control, slave returns count and flags.
interface modn_cascade_if #(
    parameter int MODULUS = 7,
    parameter int DIGITS  = 2
);
    localparam int W = $clog2(MODULUS);

    logic                  dir;
    logic                  now;
    logic                  sat;
    logic                  load;
    logic [DIGITS*W-1:0]   load_value;
    logic [DIGITS*W-1:0]   value;
    logic                  wrap;
    logic                  at_max;
    logic                  at_zero;

    modport master (
        output dir, now, sat, load, load_value,
        input  value, wrap, at_max, at_zero
    );

    modport slave (
        input  dir, now, sat, load, load_value,
        output value, wrap, at_max, at_zero
    );

endinterface

// File: rtl/modn_digit.sv
// One modulo-MODULUS digit register with load, enable and up/down rollover.
module modn_digit #(
    parameter int MODULUS = 7,
    localparam int W      = $clog2(MODULUS)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         dir,
    input  logic         load,
    input  logic [W-1:0] ld_val,
    output logic [W-1:0] value,
    output logic         at_top,
    output logic         at_bot
);
    import modn_pkg::*;

    localparam logic [W-1:0] TOP = W'(MODULUS - 1);

    logic [W-1:0] value_q;

    assign value  = value_q;
    assign at_top = (value_q == TOP);
    assign at_bot = (value_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else if (load) begin
            value_q <= ld_val;
        end else if (en) begin
            if (dir == DIR_UP) begin
                value_q <= at_top ? '0 : value_q + W'(1);
            end else begin
                value_q <= at_bot ? TOP : value_q - W'(1);
            end
        end
    end

endmodule

// File: rtl/modn_cascade.sv
// Cascaded modulo-N up/down counter: DIGITS ripple-chained digits, load, saturation, wrap pulse.
module modn_cascade #(
    parameter int MODULUS = 7,
    parameter int DIGITS  = 2
) (
    input  logic          clk,
    input  logic          rst,
    modn_cascade_if.slave bus
);
    import modn_pkg::*;

    localparam int W = $clog2(MODULUS);

    logic [DIGITS-1:0] at_top;
    logic [DIGITS-1:0] at_bot;
    logic [DIGITS-1:0] en;
    logic [W-1:0]      dval [DIGITS];
    logic              all_top;
    logic              all_bot;
    logic              full_end;
    logic              hold_end;
    logic              wrap_q;

    assign all_top  = &at_top;
    assign all_bot  = &at_bot;
    assign full_end = (bus.dir == DIR_UP) ? all_top : all_bot;
    // Saturation only suppresses the whole-chain rollover; inner carries still ripple.
    assign hold_end = bus.sat & full_end;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic         carry;
        logic [W-1:0] ld_clamped;

        if (i == 0) begin : g_lsd
            assign carry = 1'b1;
        end else begin : g_upper
            assign carry = (bus.dir == DIR_UP) ? &at_top[i-1:0] : &at_bot[i-1:0];
        end

        assign en[i]      = bus.now & carry & ~hold_end;
        assign ld_clamped = W'(digit_clamp(32'(bus.load_value[i*W +: W]), MODULUS));

        modn_digit #(.MODULUS(MODULUS)) u_digit (
            .clk    (clk),
            .rst    (rst),
            .en     (en[i]),
            .dir    (bus.dir),
            .load   (bus.load),
            .ld_val (ld_clamped),
            .value  (dval[i]),
            .at_top (at_top[i]),
            .at_bot (at_bot[i])
        );
    end

    always_comb begin
        bus.value = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            bus.value[i*W +: W] = dval[i];
        end
    end

    assign bus.at_max  = all_top;
    assign bus.at_zero = all_bot;
    assign bus.wrap    = wrap_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= ~bus.load & bus.now & ~bus.sat & full_end;
        end
    end

endmodule

// File: tb/tb_modn_cascade.sv
// Scoreboard bench for modn_cascade (MODULUS=7, DIGITS=2) against a base-7 integer model.
module tb_modn_cascade;

    localparam int MODULUS = 7;
    localparam int DIGITS  = 2;
    localparam int W       = 3;
    localparam int unsigned TOTAL = 49;

    typedef struct {
        logic [DIGITS*W-1:0] value;
        logic                wrap;
        logic                at_max;
        logic                at_zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    modn_cascade_if #(.MODULUS(MODULUS), .DIGITS(DIGITS)) bus ();

    modn_cascade #(.MODULUS(MODULUS), .DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t        sb[$];
    int unsigned m_n;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [DIGITS*W-1:0] pk(input int unsigned d1, input int unsigned d0);
        logic [DIGITS*W-1:0] r;
        r = {3'(d1), 3'(d0)};
        return r;
    endfunction

    function automatic logic [DIGITS*W-1:0] enc(input int unsigned n);
        return pk(n / 7, n % 7);
    endfunction

    // Drive one cycle, push model expectation, then pop and compare after the edge.
    task automatic cycle(input string tag, input logic r, input logic l, input logic nw,
                         input logic d, input logic s, input logic [DIGITS*W-1:0] lv);
        logic        w;
        int unsigned d0, d1;
        exp_t        e;
        @(negedge clk);
        rst = r; bus.load = l; bus.now = nw; bus.dir = d; bus.sat = s; bus.load_value = lv;
        w = 1'b0;
        if (r) begin
            m_n = 0;
        end else if (l) begin
            d0 = lv[2:0]; d1 = lv[5:3];
            if (d0 > 6) d0 = 6;
            if (d1 > 6) d1 = 6;
            m_n = d1 * 7 + d0;
        end else if (nw) begin
            if (d) begin
                if (m_n == TOTAL - 1) begin
                    if (!s) begin m_n = 0; w = 1'b1; end
                end else m_n++;
            end else begin
                if (m_n == 0) begin
                    if (!s) begin m_n = TOTAL - 1; w = 1'b1; end
                end else m_n--;
            end
        end
        sb.push_back('{enc(m_n), w, (m_n == TOTAL - 1), (m_n == 0)});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, ".value"},   32'(bus.value),   32'(e.value));
        check({tag, ".wrap"},    32'(bus.wrap),    32'(e.wrap));
        check({tag, ".at_max"},  32'(bus.at_max),  32'(e.at_max));
        check({tag, ".at_zero"}, 32'(bus.at_zero), 32'(e.at_zero));
    endtask

    initial begin
        rst = 1'b1; bus.load = 1'b0; bus.now = 1'b0; bus.dir = 1'b1; bus.sat = 1'b0;
        bus.load_value = '0;
        m_n = 0;

        // Reset dominates load and now
        cycle("rst", 1, 1, 1, 1, 0, pk(3, 3));
        check("rst_val", 32'(bus.value), 32'(pk(0, 0)));
        check("rst_zero", 32'(bus.at_zero), 32'd1);
        cycle("ld42", 0, 1, 0, 1, 0, pk(4, 2));
        cycle("rst_mid", 1, 0, 1, 1, 0, '0);
        check("rst_mid_val", 32'(bus.value), 32'(pk(0, 0)));

        // Up sweep to top, then wrap
        for (int i = 0; i < 48; i++) cycle("up", 0, 0, 1, 1, 0, '0);
        check("sweep_top", 32'(bus.value), 32'(pk(6, 6)));
        check("sweep_max", 32'(bus.at_max), 32'd1);
        cycle("up_wrap", 0, 0, 1, 1, 0, '0);
        check("wrap_pulse", 32'(bus.wrap), 32'd1);
        check("wrap_val", 32'(bus.value), 32'(pk(0, 0)));
        cycle("up_after", 0, 0, 1, 1, 0, '0);
        check("wrap_one", 32'(bus.wrap), 32'd0);
        cycle("ld06", 0, 1, 0, 1, 0, pk(0, 6));
        cycle("carry", 0, 0, 1, 1, 0, '0);
        check("carry_val", 32'(bus.value), 32'(pk(1, 0)));

        // Down wrap
        cycle("ld00", 0, 1, 0, 0, 0, pk(0, 0));
        cycle("dn_wrap", 0, 0, 1, 0, 0, '0);
        check("dn_wrap_val", 32'(bus.value), 32'(pk(6, 6)));
        check("dn_wrap_pulse", 32'(bus.wrap), 32'd1);
        cycle("dn", 0, 0, 1, 0, 0, '0);
        check("dn_val", 32'(bus.value), 32'(pk(6, 5)));

        // Saturation at both ends
        cycle("ld66", 0, 1, 0, 1, 1, pk(6, 6));
        for (int i = 0; i < 3; i++) cycle("sat_up", 0, 0, 1, 1, 1, '0);
        check("sat_up_val", 32'(bus.value), 32'(pk(6, 6)));
        cycle("ld00s", 0, 1, 0, 0, 1, pk(0, 0));
        for (int i = 0; i < 3; i++) cycle("sat_dn", 0, 0, 1, 0, 1, '0);
        check("sat_dn_val", 32'(bus.value), 32'(pk(0, 0)));
        cycle("ld06s", 0, 1, 0, 1, 1, pk(0, 6));
        cycle("sat_carry", 0, 0, 1, 1, 1, '0);
        check("sat_carry_val", 32'(bus.value), 32'(pk(1, 0)));

        // Load, clamping, load beats now
        cycle("ld31", 0, 1, 0, 1, 0, pk(3, 1));
        check("ld31_val", 32'(bus.value), 32'(pk(3, 1)));
        cycle("ld_clamp0", 0, 1, 0, 1, 0, pk(2, 7));
        check("clamp0_val", 32'(bus.value), 32'(pk(2, 6)));
        cycle("ld_clamp1", 0, 1, 0, 1, 0, pk(7, 7));
        cycle("ld_now", 0, 1, 1, 1, 0, pk(3, 1));
        check("ld_now_val", 32'(bus.value), 32'(pk(3, 1)));

        // Hold with dir/sat toggling
        for (int i = 0; i < 10; i++) cycle("hold", 0, 0, 0, 1'(i), 1'(i >> 1), '0);
        check("hold_val", 32'(bus.value), 32'(pk(3, 1)));

        // Random mix
        for (int i = 0; i < 300; i++) begin
            cycle("rand", ($urandom_range(0, 49) == 0), ($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 3) == 0),
                  6'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
